// File: rtl/bip_shift_alu_datapath.sv
// bip_shift_alu_datapath
//   Accumulator datapath for a basic instruction processor. A step is accepted
//   when i_valid && o_ready. Non-shift steps complete in one cycle; SHL/SRA
//   steps routed into the accumulator shift one bit per cycle for B[3:0]
//   cycles. o_done pulses for one cycle after every completed step.
//
// Ports
//   i_clock, i_reset     clock, synchronous active-high reset
//   i_valid / o_ready    step handshake (o_ready high only while idle)
//   i_ram_data           RAM read data (mux A source 00, ALU B when i_sel_b=0)
//   i_operand            instruction operand (sign-extended for mux A / ALU B)
//   i_sel_a              accumulator source: 00 RAM, 01 sext, 10 ALU, 11 hold
//   i_sel_b              ALU B source: 0 RAM data, 1 sext operand
//   i_alu_op             ADD SUB AND OR XOR SHL SRA PASSB (000..111)
//   i_enb_acc            accumulator write enable
//   o_acc                accumulator
//   o_ram_addr           operand zero-extended/truncated to NB_ADDR
//   o_ram_data           accumulator (store data)
//   o_zero/o_neg/o_carry/o_ovf  status flags
//   o_done               step-complete pulse
module bip_shift_alu_datapath #(
  parameter int NB_DATA    = 16,
  parameter int NB_ADDR    = 11,
  parameter int NB_OPERAND = 11,
  parameter int NB_SEL_A   = 2,
  parameter int NB_ALU_OP  = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [NB_DATA-1:0]    i_ram_data,
  input  logic [NB_OPERAND-1:0] i_operand,
  input  logic [NB_SEL_A-1:0]   i_sel_a,
  input  logic                  i_sel_b,
  input  logic [NB_ALU_OP-1:0]  i_alu_op,
  input  logic                  i_enb_acc,
  output logic [NB_DATA-1:0]    o_acc,
  output logic [NB_ADDR-1:0]    o_ram_addr,
  output logic [NB_DATA-1:0]    o_ram_data,
  output logic                  o_zero,
  output logic                  o_neg,
  output logic                  o_carry,
  output logic                  o_ovf,
  output logic                  o_done
);

  localparam logic [NB_ALU_OP-1:0] OP_ADD = NB_ALU_OP'(0);
  localparam logic [NB_ALU_OP-1:0] OP_SUB = NB_ALU_OP'(1);
  localparam logic [NB_ALU_OP-1:0] OP_AND = NB_ALU_OP'(2);
  localparam logic [NB_ALU_OP-1:0] OP_OR  = NB_ALU_OP'(3);
  localparam logic [NB_ALU_OP-1:0] OP_XOR = NB_ALU_OP'(4);
  localparam logic [NB_ALU_OP-1:0] OP_SHL = NB_ALU_OP'(5);
  localparam logic [NB_ALU_OP-1:0] OP_SRA = NB_ALU_OP'(6);
  localparam logic [NB_ALU_OP-1:0] OP_PASSB = NB_ALU_OP'(7);

  localparam logic [NB_SEL_A-1:0] SEL_RAM  = NB_SEL_A'(0);
  localparam logic [NB_SEL_A-1:0] SEL_SEXT = NB_SEL_A'(1);
  localparam logic [NB_SEL_A-1:0] SEL_ALU  = NB_SEL_A'(2);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] acc_q, acc_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               sra_q, sra_d;

  logic [NB_DATA-1:0]         sext;
  logic [NB_DATA-1:0]         b_val;
  logic [NB_DATA-1:0]         alu_res;
  logic                       alu_c;
  logic                       alu_v;
  logic [NB_DATA-1:0]         mux_a;
  logic [NB_DATA:0]           sum_ext;
  logic [NB_DATA:0]           diff_ext;
  logic [NB_DATA-1:0]         shifted;
  logic                       shift_out;
  logic                       shift_op;
  logic [NB_ADDR+NB_OPERAND-1:0] addr_wide;

  // Operand decode, ALU and mux A.
  always_comb begin
    sext = {NB_DATA{i_operand[NB_OPERAND-1]}};
    sext[NB_OPERAND-1:0] = i_operand;

    b_val = i_sel_b ? sext : i_ram_data;

    sum_ext  = {1'b0, acc_q} + {1'b0, b_val};
    diff_ext = {1'b0, acc_q} - {1'b0, b_val};

    alu_res = acc_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (i_alu_op)
      OP_ADD: begin
        alu_res = sum_ext[NB_DATA-1:0];
        alu_c   = sum_ext[NB_DATA];
        alu_v   = (acc_q[NB_DATA-1] == b_val[NB_DATA-1]) &&
                  (alu_res[NB_DATA-1] != acc_q[NB_DATA-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[NB_DATA-1:0];
        alu_c   = diff_ext[NB_DATA];  // borrow: acc < B unsigned
        alu_v   = (acc_q[NB_DATA-1] != b_val[NB_DATA-1]) &&
                  (alu_res[NB_DATA-1] != acc_q[NB_DATA-1]);
      end
      OP_AND:   alu_res = acc_q & b_val;
      OP_OR:    alu_res = acc_q | b_val;
      OP_XOR:   alu_res = acc_q ^ b_val;
      OP_PASSB: alu_res = b_val;
      default:  alu_res = acc_q;       // shifts are handled by the FSM
    endcase

    case (i_sel_a)
      SEL_RAM:  mux_a = i_ram_data;
      SEL_SEXT: mux_a = sext;
      SEL_ALU:  mux_a = alu_res;
      default:  mux_a = acc_q;
    endcase

    shift_op = (i_alu_op == OP_SHL) || (i_alu_op == OP_SRA);

    if (sra_q) begin
      shifted   = {acc_q[NB_DATA-1], acc_q[NB_DATA-1:1]};
      shift_out = acc_q[0];
    end else begin
      shifted   = {acc_q[NB_DATA-2:0], 1'b0};
      shift_out = acc_q[NB_DATA-1];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    sra_d   = sra_q;

    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          done_d = 1'b1;
          if (i_enb_acc) begin
            if ((i_sel_a == SEL_ALU) && shift_op) begin
              if (b_val[3:0] == 4'd0) begin
                zero_d  = (acc_q == '0);
                neg_d   = acc_q[NB_DATA-1];
                carry_d = 1'b0;
                ovf_d   = 1'b0;
              end else begin
                state_d = ST_SHIFT;
                cnt_d   = b_val[3:0];
                sra_d   = (i_alu_op == OP_SRA);
                done_d  = 1'b0;
              end
            end else begin
              acc_d = mux_a;
              if (i_sel_a == SEL_ALU) begin
                zero_d  = (alu_res == '0);
                neg_d   = alu_res[NB_DATA-1];
                carry_d = alu_c;
                ovf_d   = alu_v;
              end
            end
          end
        end
      end
      ST_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - 4'd1;
        // Flags are committed only on the last step, so carry is the final bit out.
        if (cnt_q == 4'd1) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          zero_d  = (shifted == '0);
          neg_d   = shifted[NB_DATA-1];
          carry_d = shift_out;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sra_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sra_q   <= sra_d;
    end
  end

  always_comb begin
    addr_wide  = {{NB_ADDR{1'b0}}, i_operand};
    o_ram_addr = addr_wide[NB_ADDR-1:0];
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_acc      = acc_q;
  assign o_ram_data = acc_q;
  assign o_zero     = zero_q;
  assign o_neg      = neg_q;
  assign o_carry    = carry_q;
  assign o_ovf      = ovf_q;
  assign o_done     = done_q;

endmodule
